shift_arbiter: RTL and testbench

- Shares one combinational shift core between NREQ requesters, such as the execute stage and the address-generation path.
- Each requester issues operand, amount and op with a valid/ready handshake. A round-robin arbiter grants one request per cycle.
- The result and NZC flags are registered and returned to the granted requester through a per-requester valid/ready response channel.
- Sits beside the ALU and owns all shifter traffic.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_arbiter_if.sv | 31 +++
 rtl/shift_core.sv | 42 ++++
 rtl/shift_arbiter.sv | 104 ++++++++++
 tb/tb_shift_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: op encoding, default widths and the result-slot record.
package shift_pkg;

  localparam int W_DEF   = 32;
  localparam int SHW_DEF = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [W_DEF-1:0] data;
    logic             c;
    logic             z;
    logic             n;
  } shift_rsp_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between NREQ requesters (master) and the shared shifter (slave).
interface shift_arbiter_if #(
  parameter int W    = 32,
  parameter int NREQ = 2,
  parameter int SHW  = $clog2(W)
) ();

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_num;
  logic [SHW*NREQ-1:0] req_amt;
  logic [NREQ-1:0]     req_cin;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [W-1:0]        rsp_data;
  logic                rsp_c;
  logic                rsp_z;
  logic                rsp_n;

  modport master (
    output req_valid, req_op, req_num, req_amt, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n
  );

  modport slave (
    input  req_valid, req_op, req_num, req_amt, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n
  );

endinterface

// File: rtl/shift_core.sv
// Combinational barrel shifter: LSL/LSR/ASR/ROR with carry-out; amount 0 passes num and cin.
module shift_core
  import shift_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int SHW = SHW_DEF
) (
  input  logic [W-1:0]   num_i,
  input  logic [SHW-1:0] amt_i,
  input  shift_op_e      op_i,
  input  logic           cin_i,
  output logic [W-1:0]   result_o,
  output logic           c_o
);

  // One extra guard bit on each side captures the last bit shifted out as carry.
  logic [W:0]        lsl_ext;
  logic [W:0]        lsr_ext;
  logic signed [W:0] asr_ext;
  logic [SHW:0]      ror_back;
  logic [W-1:0]      ror_res;

  always_comb begin
    lsl_ext  = {1'b0, num_i} << amt_i;
    lsr_ext  = {num_i, 1'b0} >> amt_i;
    asr_ext  = $signed({num_i, 1'b0}) >>> amt_i;
    ror_back = (SHW+1)'(W) - {1'b0, amt_i};
    ror_res  = (num_i >> amt_i) | (num_i << ror_back);

    result_o = num_i;
    c_o      = cin_i;
    if (amt_i != '0) begin
      unique case (op_i)
        SH_LSL: begin result_o = lsl_ext[W-1:0]; c_o = lsl_ext[W];   end
        SH_LSR: begin result_o = lsr_ext[W:1];   c_o = lsr_ext[0];   end
        SH_ASR: begin result_o = asr_ext[W:1];   c_o = asr_ext[0];   end
        SH_ROR: begin result_o = ror_res;        c_o = ror_res[W-1]; end
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core among NREQ requesters, with a single
// registered result slot returned to the granted requester over valid/ready.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = 2,
  parameter int SHW  = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          full_q,  full_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q,   ptr_d;
  shift_rsp_t    rsp_q,   rsp_d;

  logic          found;
  logic [OW-1:0] win;
  int            win_idx;
  logic          can_accept;
  logic          accept;
  logic [W-1:0]  core_res;
  logic          core_c;

  // Winner search starts at the pointer and wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = OW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign win_idx    = int'(win);
  assign can_accept = !full_q || bus.rsp_ready[owner_q];
  assign accept     = found && can_accept && rst_n;

  shift_core #(.W(W), .SHW(SHW)) u_core (
    .num_i    (bus.req_num[W*win_idx +: W]),
    .amt_i    (bus.req_amt[SHW*win_idx +: SHW]),
    .op_i     (shift_op_e'(bus.req_op[2*win_idx +: 2])),
    .cin_i    (bus.req_cin[win_idx]),
    .result_o (core_res),
    .c_o      (core_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      rsp_q   <= '0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      rsp_q   <= rsp_d;
    end
  end

  // A new accept always wins over a drain, so rsp_valid never bubbles on reload.
  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    rsp_d   = rsp_q;
    if (accept) begin
      full_d     = 1'b1;
      owner_d    = win;
      ptr_d      = OW'((int'(win) + 1) % NREQ);
      rsp_d.data = W_DEF'(core_res);
      rsp_d.c    = core_c;
      rsp_d.z    = (core_res == '0);
      rsp_d.n    = core_res[W-1];
    end else if (full_q && bus.rsp_ready[owner_q]) begin
      full_d = 1'b0;
    end
  end

  assign bus.req_ready = accept ? (NREQ'(1) << win) : '0;
  assign bus.rsp_valid = full_q ? (NREQ'(1) << owner_q) : '0;
  assign bus.rsp_data  = rsp_q.data[W-1:0];
  assign bus.rsp_c     = rsp_q.c;
  assign bus.rsp_z     = rsp_q.z;
  assign bus.rsp_n     = rsp_q.n;

  // Requesters must hold valid and payload until accepted; violations are flagged, not repaired.
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
        (bus.req_valid[i] &&
         $stable({bus.req_op[2*i +: 2], bus.req_num[W*i +: W],
                  bus.req_amt[SHW*i +: SHW], bus.req_cin[i]})));
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table, hand-written corner sequences, random traffic vs. model.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int W = 32, NREQ = 2, SHW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if #(.W(W), .NREQ(NREQ), .SHW(SHW)) bus ();
  shift_arbiter #(.W(W), .NREQ(NREQ), .SHW(SHW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [1:0]  p_op  [NREQ];
  logic [31:0] p_num [NREQ];
  logic [4:0]  p_amt [NREQ];
  logic        p_cin [NREQ];

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [31:0] num;
    logic [4:0]  amt;
    logic        cin;
    logic [31:0] e_data;
    logic        e_c, e_z, e_n;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        c, z, n;
    int          owner;
  } rsp_t;

  vec_t tbl [10];
  rsp_t slot [$];
  int   m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_p(input int i, input logic [1:0] op, input logic [31:0] num,
                       input logic [4:0] amt, input logic cin);
    p_op[i] = op; p_num[i] = num; p_amt[i] = amt; p_cin[i] = cin;
  endtask

  task automatic settle();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[2*i +: 2]   = p_op[i];
      bus.req_num[32*i +: 32] = p_num[i];
      bus.req_amt[5*i +: 5]  = p_amt[i];
      bus.req_cin[i]         = p_cin[i];
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference shifter built from plain arithmetic on wide integers.
  function automatic void ref_shift(input logic [1:0] op, input logic [31:0] num, input int n,
                                    input logic cin, output logic [31:0] res, output logic c);
    longint unsigned u;
    longint s;
    u = 64'(num);
    res = num;
    c = cin;
    if (n != 0) begin
      case (op)
        2'd0: begin res = 32'((u * (64'd1 << n)) % (64'd1 << 32)); c = 1'((u >> (32 - n)) & 1); end
        2'd1: begin res = 32'(u / (64'd1 << n));                  c = 1'((u >> (n - 1)) & 1); end
        2'd2: begin
          s = num[31] ? (longint'(u) - 64'sd4294967296) : longint'(u);
          res = 32'(s >>> n);
          c = 1'((u >> (n - 1)) & 1);
        end
        default: begin
          for (int k = 0; k < n; k++) res = {res[0], res[31:1]};
          c = res[31];
        end
      endcase
    end
  endfunction

  initial begin
    logic [1:0]  v;
    logic [1:0]  pend;
    logic [1:0]  exp_rv, exp_rdy;
    logic [31:0] r_data;
    logic        r_c;
    bit          can;
    int          w;

    tbl[0] = '{0, 2'd1, 32'h8000_0001, 5'd1,  1'b0, 32'h4000_0000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1, 2'd2, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{0, 2'd3, 32'h0000_0001, 5'd1,  1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1, 2'd0, 32'h8000_0000, 5'd1,  1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{0, 2'd0, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1, 2'd3, 32'h0000_0000, 5'd0,  1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{0, 2'd0, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1, 2'd1, 32'hF000_0000, 5'd4,  1'b1, 32'h0F00_0000, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{0, 2'd2, 32'h7FFF_FFFF, 5'd4,  1'b0, 32'h07FF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1, 2'd3, 32'h0000_000F, 5'd4,  1'b0, 32'hF000_0000, 1'b1, 1'b0, 1'b1};

    // Reset with both requesters asserting valid.
    set_p(0, 2'd0, 32'h1, 5'd4, 1'b0);
    set_p(1, 2'd3, 32'h3, 5'd1, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    settle();
    repeat (2) begin
      tick();
      check("rst_rsp_valid", bus.rsp_valid, 2'b00);
      check("rst_req_ready", bus.req_ready, 2'b00);
    end
    check("rst_data_flags", {bus.rsp_data, bus.rsp_c, bus.rsp_z, bus.rsp_n}, 35'h0);

    // Contention: grants alternate starting at requester 0, no bubbles.
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("cont%0d_ready", k), bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check($sformatf("cont%0d_rsp_valid", k), bus.rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
        check($sformatf("cont%0d_data", k), bus.rsp_data, (k % 2 == 1) ? 32'h10 : 32'h8000_0001);
      end
      tick();
    end
    bus.req_valid = 2'b01;
    settle();
    check("cont6_ready", bus.req_ready, 2'b01);
    check("cont6_rsp_valid", bus.rsp_valid, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    settle();
    check("cont7_rsp_valid", bus.rsp_valid, 2'b01);
    check("cont7_data", bus.rsp_data, 32'h10);
    tick();

    // Semantics table: one request, response next cycle.
    for (int k = 0; k < 10; k++) begin
      set_p(tbl[k].req, tbl[k].op, tbl[k].num, tbl[k].amt, tbl[k].cin);
      bus.req_valid = 2'b01 << tbl[k].req;
      bus.rsp_ready = 2'b11;
      settle();
      check($sformatf("tbl%0d_ready", k), bus.req_ready, 2'b01 << tbl[k].req);
      tick();
      bus.req_valid = 2'b00;
      settle();
      check($sformatf("tbl%0d_rsp_valid", k), bus.rsp_valid, 2'b01 << tbl[k].req);
      check($sformatf("tbl%0d_data", k), bus.rsp_data, tbl[k].e_data);
      check($sformatf("tbl%0d_czn", k), {bus.rsp_c, bus.rsp_z, bus.rsp_n},
            {tbl[k].e_c, tbl[k].e_z, tbl[k].e_n});
      tick();
    end
    check("tbl_drained", bus.rsp_valid, 2'b00);

    // Backpressure: slot owned by req1, non-owner ready bit set and ignored.
    set_p(1, 2'd1, 32'h80, 5'd3, 1'b0);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    settle();
    check("bp_load_ready", bus.req_ready, 2'b10);
    tick();
    set_p(0, 2'd0, 32'hFF, 5'd8, 1'b0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("bp%0d_ready", k), bus.req_ready, 2'b00);
      check($sformatf("bp%0d_rsp_valid", k), bus.rsp_valid, 2'b10);
      check($sformatf("bp%0d_data", k), bus.rsp_data, 32'h10);
      tick();
    end
    bus.rsp_ready = 2'b10;
    settle();
    check("bp_release_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    settle();
    check("bp_reload_valid", bus.rsp_valid, 2'b01);
    check("bp_reload_data", bus.rsp_data, 32'h0000_FF00);
    tick();

    // Reset mid-operation: full slot discarded, pointer back to 0.
    set_p(0, 2'd2, 32'h8000_0000, 5'd4, 1'b0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    settle();
    check("rmid_load_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    settle();
    check("rmid_full", bus.rsp_valid, 2'b01);
    check("rmid_full_data", bus.rsp_data, 32'hF800_0000);
    rst_n = 1'b0;
    tick();
    check("rmid_rsp_valid", bus.rsp_valid, 2'b00);
    check("rmid_data", bus.rsp_data, 32'h0);
    rst_n = 1'b1;
    set_p(0, 2'd0, 32'h5, 5'd1, 1'b0);
    set_p(1, 2'd1, 32'h5, 5'd1, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    settle();
    check("rmid_ptr0_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b10;
    settle();
    check("rmid_next_ready", bus.req_ready, 2'b10);
    check("rmid_next_data", bus.rsp_data, 32'hA);
    tick();
    bus.req_valid = 2'b00;
    settle();
    check("rmid_last_valid", bus.rsp_valid, 2'b10);
    check("rmid_last_data", bus.rsp_data, 32'h2);
    tick();

    // Random traffic against the transaction-level model.
    m_ptr = 0;
    pend = 2'b00;
    v = 2'b00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 3))
            0: p_num[i] = 32'h8000_0000;
            1: p_num[i] = 32'h0;
            default: p_num[i] = $urandom;
          endcase
          p_op[i]  = 2'($urandom_range(0, 3));
          p_amt[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          p_cin[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.req_valid = v;
      bus.rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      settle();

      exp_rv = (slot.size() != 0) ? (2'b01 << slot[0].owner) : 2'b00;
      check($sformatf("rnd%0d_rsp_valid", cyc), bus.rsp_valid, exp_rv);
      if (slot.size() != 0)
        check($sformatf("rnd%0d_rsp", cyc), {bus.rsp_data, bus.rsp_c, bus.rsp_z, bus.rsp_n},
              {slot[0].data, slot[0].c, slot[0].z, slot[0].n});

      can = (slot.size() == 0) || bus.rsp_ready[slot[0].owner];
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      exp_rdy = (w >= 0 && can) ? (2'b01 << w) : 2'b00;
      check($sformatf("rnd%0d_ready", cyc), bus.req_ready, exp_rdy);

      if (slot.size() != 0 && bus.rsp_ready[slot[0].owner]) void'(slot.pop_front());
      if (exp_rdy != 2'b00) begin
        ref_shift(p_op[w], p_num[w], int'(p_amt[w]), p_cin[w], r_data, r_c);
        slot.push_back('{r_data, r_c, (r_data == 32'h0), r_data[31], w});
        m_ptr = (w + 1) % NREQ;
      end
      pend = v & ~exp_rdy;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
